// File: rtl/cblock_chain_cfg.sv
// Connection block: serial-scan configured switch points joining W highway
// tracks with a down-going and an up-going vertical chain. The scan chain
// loads a shadow image; a commit copies it to the active register only when
// the bit count and (optionally) even parity check out.

// One crossing: vertical up-chain stage, highway tap, down-chain stage.
module cblock_chain_lane (
  input  logic u_prev,   // up-chain value arriving from the lane below
  input  logic dn_next,  // down-chain value arriving from the lane above
  input  logic left_i,
  input  logic vu,
  input  logic lu,
  input  logic dr,
  input  logic vd,
  input  logic ld,
  input  logic ur,
  output logic u_cur,
  output logic dn_cur,
  output logic right_o
);
  logic h;

  // Pure OR-mux network: overlapping enables merge instead of contending.
  always_comb begin
    u_cur   = (u_prev & vu) | (left_i & lu);
    h       = left_i | (u_prev & dr);
    dn_cur  = (dn_next & vd) | (h & ld);
    right_o = h | (dn_next & ur);
  end
endmodule

module cblock_chain_cfg #(
  parameter int W      = 3,
  parameter int PARITY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_si,
  input  logic         cfg_shift,
  input  logic         cfg_commit,
  output logic         cfg_so,
  output logic         cfg_err,
  output logic         cfg_live,
  input  logic [W-1:0] left_i,
  output logic [W-1:0] right_o,
  input  logic         up_i,
  output logic         down_o,
  input  logic         down_i,
  output logic         up_o
);
  localparam int CFG_BITS = 6 * W;
  localparam int L        = CFG_BITS + PARITY;
  localparam int CW       = $clog2(L + 2);

  typedef enum logic {ST_EMPTY = 1'b0, ST_LIVE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [L-1:0]        s_q, s_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CFG_BITS-1:0] a_q, a_d;
  logic                err_q, err_d;
  logic                live_q, live_d;
  logic                par_ok, accept;

  // Commit is only meaningful on a complete, quiescent, parity-clean chain.
  always_comb begin
    par_ok = (PARITY == 0) || (^s_q == 1'b0);
    accept = (cnt_q == CW'(L)) && par_ok && !cfg_shift;
  end

  // Next-state: shift/count, then commit (commit always clears the counter).
  always_comb begin
    s_d     = s_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    err_d   = err_q;
    state_d = state_q;
    if (cfg_shift) begin
      s_d = {s_q[L-2:0], cfg_si};
      if (cnt_q != CW'(L + 1)) cnt_d = cnt_q + CW'(1);
    end
    if (cfg_commit) begin
      cnt_d = '0;
      if (accept) begin
        a_d     = s_q[L-1 -: CFG_BITS];
        err_d   = 1'b0;
        state_d = ST_LIVE;
      end else begin
        err_d = 1'b1;
      end
    end
    live_d = (state_d == ST_LIVE);
  end

  // All config state plus the EMPTY/LIVE FSM and its registered flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
      state_q <= ST_EMPTY;
    end else begin
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      err_q   <= err_d;
      live_q  <= live_d;
      state_q <= state_d;
    end
  end

  assign cfg_so   = s_q[L-1];
  assign cfg_err  = err_q;
  assign cfg_live = live_q;

  // Active image fields, MSB first: VD VU LU DR UR LD.
  logic [W-1:0] vd, vu, lu, dr, ur, ld;
  assign vd = a_q[6*W-1 -: W];
  assign vu = a_q[5*W-1 -: W];
  assign lu = a_q[4*W-1 -: W];
  assign dr = a_q[3*W-1 -: W];
  assign ur = a_q[2*W-1 -: W];
  assign ld = a_q[W-1:0];

  // u[0] is the bottom entry; dn[W] is the top entry. Up-chain runs low to
  // high index, down-chain high to low, so the lanes never form a loop.
  logic [W:0] u, dn;
  assign u[0]  = down_i;
  assign dn[W] = up_i;

  for (genvar i = 0; i < W; i++) begin : g_lane
    cblock_chain_lane u_lane (
      .u_prev  (u[i]),
      .dn_next (dn[i+1]),
      .left_i  (left_i[i]),
      .vu      (vu[i]),
      .lu      (lu[i]),
      .dr      (dr[i]),
      .vd      (vd[i]),
      .ld      (ld[i]),
      .ur      (ur[i]),
      .u_cur   (u[i+1]),
      .dn_cur  (dn[i]),
      .right_o (right_o[i])
    );
  end

  assign up_o   = u[W];
  assign down_o = dn[0];
endmodule

// File: tb/tb_cblock_chain_cfg.sv
// Directed bench: two daisy-chained blocks (W=3, parity on). Routing is
// checked from a table of hand-computed vectors per configured image.
module tb_cblock_chain_cfg;
  logic       clk = 1'b0;
  logic       rst;
  logic       si, shift0, shift1, commit0, commit1;
  logic [2:0] left;
  logic       up_in, down_in;
  logic       so0, so1, err0, err1, live0, live1;
  logic [2:0] right0, right1;
  logic       dno0, dno1, upo0, upo1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cblock_chain_cfg #(.W(3), .PARITY(1)) dut0 (
    .clk(clk), .rst(rst), .cfg_si(si), .cfg_shift(shift0), .cfg_commit(commit0),
    .cfg_so(so0), .cfg_err(err0), .cfg_live(live0),
    .left_i(left), .right_o(right0), .up_i(up_in), .down_o(dno0),
    .down_i(down_in), .up_o(upo0));

  cblock_chain_cfg #(.W(3), .PARITY(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_si(so0), .cfg_shift(shift1), .cfg_commit(commit1),
    .cfg_so(so1), .cfg_err(err1), .cfg_live(live1),
    .left_i(left), .right_o(right1), .up_i(up_in), .down_o(dno1),
    .down_i(down_in), .up_o(upo1));

  // Images: layout VD VU LU DR UR LD, 3 bits each.
  localparam logic [17:0] IMG1  = 18'h20001; // VD[2], LD[0]
  localparam logic [17:0] IMG2A = 18'h07000; // VU=111
  localparam logic [17:0] IMG2B = 18'h07080; // VU=111, DR[1]
  localparam logic [17:0] IMG3  = 18'h1C40C; // VD=011 VU=100 LU=010 UR=001 LD=100

  typedef struct {
    int         img;
    logic [2:0] left;
    logic       up_i;
    logic       down_i;
    logic [2:0] exp_right;
    logic       exp_up;
    logic       exp_down;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] chain(input logic [17:0] img, input logic flip);
    return {img, (^img) ^ flip};
  endfunction

  // Shifts the low n bits of bits, MSB first, into the selected instances.
  task automatic stream(input logic [37:0] bits, input int n, input logic s0, input logic s1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      si = bits[n-1-i];
      shift0 = s0;
      shift1 = s1;
    end
    @(negedge clk);
    shift0 = 1'b0;
    shift1 = 1'b0;
    si = 1'b0;
  endtask

  task automatic commit(input logic c0, input logic c1);
    @(negedge clk);
    commit0 = c0;
    commit1 = c1;
    @(negedge clk);
    commit0 = 1'b0;
    commit1 = 1'b0;
  endtask

  task automatic run_vecs(input int img, input int which, input string tag);
    foreach (tbl[k]) begin
      if (tbl[k].img == img) begin
        left = tbl[k].left;
        up_in = tbl[k].up_i;
        down_in = tbl[k].down_i;
        #1;
        if (which == 0)
          chk($sformatf("%s_v%0d", tag, k), {3'b0, right0, upo0, dno0},
              {3'b0, tbl[k].exp_right, tbl[k].exp_up, tbl[k].exp_down});
        else
          chk($sformatf("%s_v%0d", tag, k), {3'b0, right1, upo1, dno1},
              {3'b0, tbl[k].exp_right, tbl[k].exp_up, tbl[k].exp_down});
      end
    end
  endtask

  task automatic chk_flags(input string name, input int which, input logic e, input logic lv);
    if (which == 0) chk(name, {6'b0, err0, live0}, {6'b0, e, lv});
    else            chk(name, {6'b0, err1, live1}, {6'b0, e, lv});
  endtask

  initial begin
    // img 0: all switches off -> pass-through
    tbl.push_back('{0, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{0, 3'b101, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0});
    tbl.push_back('{0, 3'b011, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0});
    // img 1: down_o = left[0]; up_i blocked at VD[1]
    tbl.push_back('{1, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{1, 3'b001, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1});
    tbl.push_back('{1, 3'b110, 1'b1, 1'b1, 3'b110, 1'b0, 1'b0});
    tbl.push_back('{1, 3'b101, 1'b1, 1'b1, 3'b101, 1'b0, 1'b1});
    // img 2: up_o = down_i, right = left
    tbl.push_back('{2, 3'b010, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0});
    tbl.push_back('{2, 3'b101, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0});
    // img 3: additionally right[1] |= down_i
    tbl.push_back('{3, 3'b000, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0});
    tbl.push_back('{3, 3'b100, 1'b0, 1'b1, 3'b110, 1'b1, 1'b0});
    tbl.push_back('{3, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
    // img 4: up_o=left[1], down_o=left[2], right[0]=left[0]|left[2]
    tbl.push_back('{4, 3'b100, 1'b1, 1'b1, 3'b101, 1'b0, 1'b1});
    tbl.push_back('{4, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0});
    tbl.push_back('{4, 3'b001, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0});
    tbl.push_back('{4, 3'b110, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1});

    rst = 1'b1; si = 1'b0; shift0 = 1'b0; shift1 = 1'b0;
    commit0 = 1'b0; commit1 = 1'b0; left = '0; up_in = 1'b0; down_in = 1'b0;
    #12;
    chk_flags("reset_flags", 0, 1'b0, 1'b0);
    run_vecs(0, 0, "reset_route");
    @(negedge clk);
    rst = 1'b0;

    // Load IMG1 and go live
    stream({19'b0, chain(IMG1, 1'b0)}, 19, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    chk_flags("img1_commit", 0, 1'b0, 1'b1);
    run_vecs(1, 0, "img1");

    // Reset in the middle of a shift burst clears everything
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      si = 1'b1;
      shift0 = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    chk_flags("midshift_reset", 0, 1'b0, 1'b0);
    run_vecs(0, 0, "midshift_route");
    @(negedge clk);
    shift0 = 1'b0; si = 1'b0; rst = 1'b0;

    // Counter restarted from zero: a clean 19-bit reload is accepted
    stream({19'b0, chain(IMG1, 1'b0)}, 19, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    chk_flags("reload_img1", 0, 1'b0, 1'b1);

    // Short chain (18 bits) rejected; active image kept
    stream({20'b0, chain(IMG3, 1'b0) >> 1}, 18, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    chk_flags("short_reject", 0, 1'b1, 1'b1);
    run_vecs(1, 0, "short_keep");

    // Over-long chain (20 bits, counter saturated) rejected
    stream({18'b0, chain(IMG3, 1'b0), 1'b0}, 20, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    chk_flags("long_reject", 0, 1'b1, 1'b1);
    run_vecs(1, 0, "long_keep");

    // Bad parity rejected, then good image accepted and err clears
    stream({19'b0, chain(IMG3, 1'b1)}, 19, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    chk_flags("parity_reject", 0, 1'b1, 1'b1);
    run_vecs(1, 0, "parity_keep");
    stream({19'b0, chain(IMG3, 1'b0)}, 19, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    chk_flags("img3_accept", 0, 1'b0, 1'b1);
    run_vecs(4, 0, "img3");

    // Vertical pass-through, then DR tap onto the highway
    stream({19'b0, chain(IMG2A, 1'b0)}, 19, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    chk_flags("img2a_accept", 0, 1'b0, 1'b1);
    run_vecs(2, 0, "img2a");
    stream({19'b0, chain(IMG2B, 1'b0)}, 19, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    chk_flags("img2b_accept", 0, 1'b0, 1'b1);
    run_vecs(3, 0, "img2b");

    // Two-block chain: first block carries the far image, then both shift
    // 19 more so the far image moves downstream and the near one lands.
    chk_flags("dut1_idle", 1, 1'b0, 1'b0);
    stream({19'b0, chain(IMG1, 1'b0)}, 19, 1'b1, 1'b0);
    commit(1'b1, 1'b0);
    stream({19'b0, chain(IMG3, 1'b0)}, 19, 1'b1, 1'b1);
    commit(1'b1, 1'b1);
    chk_flags("chain_dut0", 0, 1'b0, 1'b1);
    chk_flags("chain_dut1", 1, 1'b0, 1'b1);
    run_vecs(4, 0, "chain0");
    run_vecs(1, 1, "chain1");

    // Commit while shifting is rejected, images untouched
    @(negedge clk);
    si = 1'b0; shift0 = 1'b1; shift1 = 1'b1; commit0 = 1'b1; commit1 = 1'b1;
    @(negedge clk);
    shift0 = 1'b0; shift1 = 1'b0; commit0 = 1'b0; commit1 = 1'b0;
    chk_flags("shift_commit0", 0, 1'b1, 1'b1);
    chk_flags("shift_commit1", 1, 1'b1, 1'b1);
    run_vecs(4, 0, "shift_commit_keep0");
    run_vecs(1, 1, "shift_commit_keep1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
